rob_commit: RTL and testbench
=============================

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 The block SHALL have parameter ROB_INDEX_BIT, default 3, giving the entry-index width; depth = 2^ROB_INDEX_BIT.
REQ-002 The block SHALL have these ports, one clock domain; reset is synchronous and active-high:
 clk_in  in  1  system clock, all state updates on rising edge
 rst_in  in  1  synchronous active-high reset
 rdy_in  in  1  pause when low
 issue_valid  in  1  allocate one entry this cycle
 issue_rd  in  5  destination register, 0 = no write
 issue_is_store  in  1  entry is a store
 issue_rob_id  out  ROB_INDEX_BIT  index the next allocation receives (tail)
 full  out  1  no free entry
 cdb_valid  in  1  result broadcast
 cdb_rob_id  in  ROB_INDEX_BIT  completing entry
 cdb_value  in  32  result value
 cdb_mispredict  in  1  branch resolved opposite to prediction
 cdb_target  in  32  correct next PC when mispredicted
 qry_id1, qry_id2  in  ROB_INDEX_BIT  operand lookup
 qry_ready1, qry_ready2  out  1  entry has a result
 qry_value1, qry_value2  out  32  entry result
 rf_set_id  out  5  register written at commit, 0 = none
 rf_set_value  out  32  committed value
 rf_set_rob_id  out  ROB_INDEX_BIT  index of committed entry
 store_commit  out  1  head store committed, 1-cycle pulse
 clear  out  1  pipeline flush, 1-cycle pulse
 redirect_pc  out  32  fetch target, valid while clear=1

Function
REQ-003 Entries SHALL hold: busy, ready, rd, is_store, value, mispredict, target; head/tail pointers wrap from 2^N-1 to 0; a count register of width ROB_INDEX_BIT+1 tracks occupancy.
REQ-004 full SHALL be combinational, 1 iff count = 2^N; issue_rob_id SHALL equal tail.
REQ-005 On issue_valid=1 and full=0, the tail entry SHALL become busy, not ready, with issue fields; tail increments; issue_valid while full SHALL be ignored.
REQ-006 cdb_valid SHALL set ready, value, mispredict, target of entry cdb_rob_id only if it is busy; otherwise ignored.
REQ-007 Commit: when the head entry is busy and ready at a clock edge, it SHALL retire (busy cleared, head increments); at most one retire per cycle; an entry made ready at edge N retires no earlier than edge N+1.
REQ-008 Commit outputs SHALL be registered and valid for exactly the one cycle following the retire edge: rf_set_id=rd (0 for stores), rf_set_value, rf_set_rob_id=head index, store_commit=is_store; in all other cycles rf_set_id=0 and store_commit=0.
REQ-009 Issue and retire in the same cycle SHALL leave count unchanged; issue into an entry freed by the same-cycle retire is permitted only when full was 0.
REQ-010 Retiring an entry with mispredict=1 SHALL, at the same edge, set clear=1 and redirect_pc=target for one cycle, invalidate all entries, and set head=tail=count=0; the retiring entry's rf write still occurs.
REQ-011 While clear=1, issue_valid and cdb_valid SHALL be ignored.
REQ-012 qry_readyX SHALL be busy&ready of entry qry_idX and qry_valueX its value, combinationally.
REQ-013 When rdy_in=0 all state SHALL hold and the pulse outputs SHALL not be advanced.

Reset
REQ-014 On rst_in=1 at a clock edge: all entries not busy, head=tail=count=0, rf_set_id=0, rf_set_value=0, rf_set_rob_id=0, store_commit=0, clear=0, redirect_pc=0; rst_in has priority over rdy_in.

Configuration
REQ-015 With ROB_CDB_BYPASS_EN defined, qry_readyX=1 and qry_valueX=cdb_value when cdb_valid=1 and cdb_rob_id=qry_idX targets a busy entry in the same cycle; without it, queries see only stored state (result visible the cycle after broadcast).

Verification
REQ-016 Reset, issue rd=5, CDB value 0x1234 to id 0 -> next-cycle-after-retire rf_set_id=5, rf_set_value=0x1234, rf_set_rob_id=0, count 0.
REQ-017 Issue 8 entries (depth 8) -> full=1; 9th issue ignored; retire one -> full=0, next issue gets id 0 (wrap).
REQ-018 Entries 0,1 issued; CDB completes 1 then 0 -> retire order 0 then 1, one per cycle.
REQ-019 Branch at head with cdb_mispredict=1, target 0x100, 3 younger entries -> clear=1 one cycle, redirect_pc=0x100, count=0, issue_rob_id=0.
REQ-020 Store entry completes -> store_commit=1 one cycle, rf_set_id=0.
REQ-021 CDB and query to same id same cycle -> qry_ready1=1 with ROB_CDB_BYPASS_EN, 0 without; rdy_in=0 mid-sequence freezes all state.

Source files
------------

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation at tail, out-of-order completion via CDB,
// in-order retirement at head with registered commit outputs and mispredict flush.
// Optional build macro ROB_CDB_BYPASS_EN: operand queries also see a same-cycle
// CDB broadcast to a busy entry.
module rob_commit #(
   parameter int unsigned ROB_INDEX_BIT = 3
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     issue_valid,
   input  logic [4:0]               issue_rd,
   input  logic                     issue_is_store,
   output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
   output logic                     full,
   input  logic                     cdb_valid,
   input  logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
   input  logic [31:0]              cdb_value,
   input  logic                     cdb_mispredict,
   input  logic [31:0]              cdb_target,
   input  logic [ROB_INDEX_BIT-1:0] qry_id1,
   input  logic [ROB_INDEX_BIT-1:0] qry_id2,
   output logic                     qry_ready1,
   output logic                     qry_ready2,
   output logic [31:0]              qry_value1,
   output logic [31:0]              qry_value2,
   output logic [4:0]               rf_set_id,
   output logic [31:0]              rf_set_value,
   output logic [ROB_INDEX_BIT-1:0] rf_set_rob_id,
   output logic                     store_commit,
   output logic                     clear,
   output logic [31:0]              redirect_pc
);

   localparam int unsigned DEPTH = 1 << ROB_INDEX_BIT;

   typedef logic [ROB_INDEX_BIT-1:0] idx_t;
   typedef logic [ROB_INDEX_BIT:0]   cnt_t;

   logic        busy_q     [DEPTH];
   logic        ready_q    [DEPTH];
   logic [4:0]  rd_q       [DEPTH];
   logic        is_store_q [DEPTH];
   logic [31:0] value_q    [DEPTH];
   logic        misp_q     [DEPTH];
   logic [31:0] target_q   [DEPTH];

   idx_t head_q, tail_q;
   cnt_t count_q;

   logic do_issue, do_cdb, do_retire, do_flush;

   assign full         = (count_q == cnt_t'(DEPTH));
   assign issue_rob_id = tail_q;

   // Per-cycle control decisions; the flush pulse cycle blocks new issue and completion.
   always_comb begin
      do_issue  = rdy_in & ~clear & issue_valid & ~full;
      do_cdb    = rdy_in & ~clear & cdb_valid & busy_q[cdb_rob_id];
      do_retire = rdy_in & busy_q[head_q] & ready_q[head_q];
      do_flush  = do_retire & misp_q[head_q];
   end

   // Entry storage: flush beats completion and issue; head and tail entries are distinct
   // whenever both issue and retire happen because issue requires a free slot.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            busy_q[i]     <= 1'b0;
            ready_q[i]    <= 1'b0;
            rd_q[i]       <= 5'd0;
            is_store_q[i] <= 1'b0;
            value_q[i]    <= 32'd0;
            misp_q[i]     <= 1'b0;
            target_q[i]   <= 32'd0;
         end
      end else if (do_flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            busy_q[i] <= 1'b0;
         end
      end else begin
         if (do_cdb) begin
            ready_q[cdb_rob_id]  <= 1'b1;
            value_q[cdb_rob_id]  <= cdb_value;
            misp_q[cdb_rob_id]   <= cdb_mispredict;
            target_q[cdb_rob_id] <= cdb_target;
         end
         if (do_retire) begin
            busy_q[head_q] <= 1'b0;
         end
         if (do_issue) begin
            busy_q[tail_q]     <= 1'b1;
            ready_q[tail_q]    <= 1'b0;
            rd_q[tail_q]       <= issue_rd;
            is_store_q[tail_q] <= issue_is_store;
            misp_q[tail_q]     <= 1'b0;
         end
      end
   end

   // Head/tail/occupancy bookkeeping; pointers wrap naturally at the index width.
   always_ff @(posedge clk_in) begin
      if (rst_in || do_flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_retire) head_q <= head_q + 1'b1;
         if (do_issue)  tail_q <= tail_q + 1'b1;
         count_q <= count_q + cnt_t'(do_issue) - cnt_t'(do_retire);
      end
   end

   // Registered commit and flush pulses; frozen along with everything else while rdy_in is low.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rf_set_id     <= 5'd0;
         rf_set_value  <= 32'd0;
         rf_set_rob_id <= '0;
         store_commit  <= 1'b0;
         clear         <= 1'b0;
         redirect_pc   <= 32'd0;
      end else if (rdy_in) begin
         rf_set_id    <= (do_retire && !is_store_q[head_q]) ? rd_q[head_q] : 5'd0;
         store_commit <= do_retire & is_store_q[head_q];
         clear        <= do_flush;
         if (do_retire) begin
            rf_set_value  <= value_q[head_q];
            rf_set_rob_id <= head_q;
         end
         if (do_flush) begin
            redirect_pc <= target_q[head_q];
         end
      end
   end

   // Operand lookup from stored state, optionally forwarding a same-cycle broadcast.
   always_comb begin
      qry_ready1 = busy_q[qry_id1] & ready_q[qry_id1];
      qry_value1 = value_q[qry_id1];
      qry_ready2 = busy_q[qry_id2] & ready_q[qry_id2];
      qry_value2 = value_q[qry_id2];
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_valid && cdb_rob_id == qry_id1 && busy_q[qry_id1]) begin
         qry_ready1 = 1'b1;
         qry_value1 = cdb_value;
      end
      if (cdb_valid && cdb_rob_id == qry_id2 && busy_q[qry_id2]) begin
         qry_ready2 = 1'b1;
         qry_value2 = cdb_value;
      end
`else
`endif
   end

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit (depth 8): a vector table for the main
// issue/complete/retire/store/pause flow, plus hand-written sequences for the
// full/wrap and mispredict-flush corner cases.
module tb_rob_commit;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        issue_valid, issue_is_store;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_rob_id;
   logic        full;
   logic        cdb_valid, cdb_mispredict;
   logic [2:0]  cdb_rob_id;
   logic [31:0] cdb_value, cdb_target;
   logic [2:0]  qry_id1, qry_id2;
   logic        qry_ready1, qry_ready2;
   logic [31:0] qry_value1, qry_value2;
   logic [4:0]  rf_set_id;
   logic [31:0] rf_set_value;
   logic [2:0]  rf_set_rob_id;
   logic        store_commit, clear;
   logic [31:0] redirect_pc;

   int checks = 0;
   int failures = 0;

`ifdef ROB_CDB_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   rob_commit #(.ROB_INDEX_BIT(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_store(issue_is_store),
      .issue_rob_id(issue_rob_id), .full(full),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
      .qry_id1(qry_id1), .qry_id2(qry_id2),
      .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
      .qry_value1(qry_value1), .qry_value2(qry_value2),
      .rf_set_id(rf_set_id), .rf_set_value(rf_set_value), .rf_set_rob_id(rf_set_rob_id),
      .store_commit(store_commit), .clear(clear), .redirect_pc(redirect_pc)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        rdy, iv, ist, cv;
      logic [4:0]  ird;
      logic [2:0]  cid, q1;
      logic [31:0] cval;
      logic [2:0]  e_id;
      logic        e_full, e_sc, e_qr;
      logic [4:0]  e_rf;
      logic [31:0] e_val, e_qv;
      logic [2:0]  e_rid;
   } vec_t;

   function automatic vec_t mk(int rdy, int iv, int ird, int ist, int cv, int cid, int cval,
                               int q1, int eid, int efull, int erf, int evl, int erid,
                               int esc, int eqr, int eqv);
      vec_t r;
      r.rdy = rdy[0]; r.iv = iv[0]; r.ird = 5'(ird); r.ist = ist[0];
      r.cv = cv[0]; r.cid = 3'(cid); r.cval = 32'(cval); r.q1 = 3'(q1);
      r.e_id = 3'(eid); r.e_full = efull[0]; r.e_rf = 5'(erf); r.e_val = 32'(evl);
      r.e_rid = 3'(erid); r.e_sc = esc[0]; r.e_qr = eqr[0]; r.e_qv = 32'(eqv);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int rdy, input int iv, input int ird, input int ist,
                        input int cv, input int cid, input int cval, input int misp,
                        input int tgt, input int q1);
      rdy_in = rdy[0]; issue_valid = iv[0]; issue_rd = 5'(ird); issue_is_store = ist[0];
      cdb_valid = cv[0]; cdb_rob_id = 3'(cid); cdb_value = 32'(cval);
      cdb_mispredict = misp[0]; cdb_target = 32'(tgt); qry_id1 = 3'(q1);
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
   task automatic next_cycle();
      @(posedge clk_in);
      #1;
   endtask

   // Reset held with rdy_in low to exercise reset priority.
   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_in = 1'b1;
      next_cycle();
      next_cycle();
      rst_in = 1'b0;
      rdy_in = 1'b1;
   endtask

   vec_t tbl[27];

   initial begin
      qry_id2 = 3'd0;
      rst_in = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;

      // Columns: rdy iv ird ist | cv cid cval | q1 | e_id e_full e_rf e_val e_rid e_sc e_qr e_qv
      tbl[0]  = mk(1,1,5,0, 0,0,0,       0, 0,0, 0,0,0,      0, 0,0);
      tbl[1]  = mk(1,0,0,0, 1,0,'h1234,  0, 1,0, 0,0,0,      0, BYP,'h1234);
      tbl[2]  = mk(1,0,0,0, 0,0,0,       0, 1,0, 0,0,0,      0, 1,'h1234);
      tbl[3]  = mk(1,0,0,0, 0,0,0,       0, 1,0, 5,'h1234,0, 0, 0,0);
      tbl[4]  = mk(1,0,0,0, 0,0,0,       0, 1,0, 0,0,0,      0, 0,0);
      tbl[5]  = mk(1,1,7,0, 0,0,0,       1, 1,0, 0,0,0,      0, 0,0);
      tbl[6]  = mk(1,1,9,0, 0,0,0,       1, 2,0, 0,0,0,      0, 0,0);
      tbl[7]  = mk(1,0,0,0, 1,2,'h22,    2, 3,0, 0,0,0,      0, BYP,'h22);
      tbl[8]  = mk(1,0,0,0, 1,1,'h11,    2, 3,0, 0,0,0,      0, 1,'h22);
      tbl[9]  = mk(1,0,0,0, 0,0,0,       0, 3,0, 0,0,0,      0, 0,0);
      tbl[10] = mk(1,0,0,0, 0,0,0,       0, 3,0, 7,'h11,1,   0, 0,0);
      tbl[11] = mk(1,0,0,0, 0,0,0,       0, 3,0, 9,'h22,2,   0, 0,0);
      tbl[12] = mk(1,0,0,0, 0,0,0,       0, 3,0, 0,0,0,      0, 0,0);
      tbl[13] = mk(1,1,3,1, 0,0,0,       0, 3,0, 0,0,0,      0, 0,0);
      tbl[14] = mk(1,0,0,0, 1,3,'hdead,  0, 4,0, 0,0,0,      0, 0,0);
      tbl[15] = mk(1,0,0,0, 0,0,0,       0, 4,0, 0,0,0,      0, 0,0);
      tbl[16] = mk(1,0,0,0, 0,0,0,       0, 4,0, 0,0,0,      1, 0,0);
      tbl[17] = mk(1,0,0,0, 0,0,0,       0, 4,0, 0,0,0,      0, 0,0);
      tbl[18] = mk(1,1,1,0, 0,0,0,       0, 4,0, 0,0,0,      0, 0,0);
      tbl[19] = mk(1,0,0,0, 1,4,'h44,    0, 5,0, 0,0,0,      0, 0,0);
      tbl[20] = mk(0,1,2,0, 0,0,0,       4, 5,0, 0,0,0,      0, 1,'h44);
      tbl[21] = mk(0,0,0,0, 0,0,0,       0, 5,0, 0,0,0,      0, 0,0);
      tbl[22] = mk(1,0,0,0, 0,0,0,       0, 5,0, 0,0,0,      0, 0,0);
      tbl[23] = mk(0,0,0,0, 0,0,0,       0, 5,0, 1,'h44,4,   0, 0,0);
      tbl[24] = mk(0,0,0,0, 0,0,0,       0, 5,0, 1,'h44,4,   0, 0,0);
      tbl[25] = mk(1,0,0,0, 0,0,0,       0, 5,0, 1,'h44,4,   0, 0,0);
      tbl[26] = mk(1,0,0,0, 0,0,0,       0, 5,0, 0,0,0,      0, 0,0);

      // Reset state
      do_reset();
      #4;
      chk("rst_issue_rob_id", 32'(issue_rob_id), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_rf_set_id", 32'(rf_set_id), 0);
      chk("rst_rf_set_value", rf_set_value, 0);
      chk("rst_rf_set_rob_id", 32'(rf_set_rob_id), 0);
      chk("rst_store_commit", 32'(store_commit), 0);
      chk("rst_clear", 32'(clear), 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      next_cycle();

      // Table-driven main flow
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].rdy, tbl[i].iv, tbl[i].ird, tbl[i].ist, tbl[i].cv, tbl[i].cid,
               tbl[i].cval, 0, 0, tbl[i].q1);
         #4;
         chk($sformatf("v%0d_issue_rob_id", i), 32'(issue_rob_id), 32'(tbl[i].e_id));
         chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].e_full));
         chk($sformatf("v%0d_rf_set_id", i), 32'(rf_set_id), 32'(tbl[i].e_rf));
         if (tbl[i].e_rf != 5'd0) begin
            chk($sformatf("v%0d_rf_set_value", i), rf_set_value, tbl[i].e_val);
            chk($sformatf("v%0d_rf_set_rob_id", i), 32'(rf_set_rob_id), 32'(tbl[i].e_rid));
         end
         chk($sformatf("v%0d_store_commit", i), 32'(store_commit), 32'(tbl[i].e_sc));
         chk($sformatf("v%0d_clear", i), 32'(clear), 0);
         chk($sformatf("v%0d_qry_ready1", i), 32'(qry_ready1), 32'(tbl[i].e_qr));
         if (tbl[i].e_qr) chk($sformatf("v%0d_qry_value1", i), qry_value1, tbl[i].e_qv);
         next_cycle();
      end

      // Fill to full, overflow issue ignored, retire one, wrap to id 0
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, i + 1, 0, 0, 0, 0, 0, 0, 0);
         #4;
         chk($sformatf("fill%0d_issue_rob_id", i), 32'(issue_rob_id), 32'(i));
         chk($sformatf("fill%0d_full", i), 32'(full), 0);
         next_cycle();
      end
      drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
      #4;
      chk("full_after_8", 32'(full), 1);
      chk("full_issue_rob_id", 32'(issue_rob_id), 0);
      next_cycle();
      drive(1, 0, 0, 0, 1, 0, 'h77, 0, 0, 0);
      #4;
      chk("full_after_9th", 32'(full), 1);
      chk("full_9th_ignored_id", 32'(issue_rob_id), 0);
      next_cycle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      chk("full_before_retire", 32'(full), 1);
      next_cycle();
      drive(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
      #4;
      chk("wrap_full", 32'(full), 0);
      chk("wrap_issue_rob_id", 32'(issue_rob_id), 0);
      chk("wrap_rf_set_id", 32'(rf_set_id), 1);
      chk("wrap_rf_set_value", rf_set_value, 'h77);
      next_cycle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      chk("wrap_refull", 32'(full), 1);
      chk("wrap_next_id", 32'(issue_rob_id), 1);
      chk("wrap_new_not_ready", 32'(qry_ready1), 0);
      next_cycle();

      // Mispredicted branch at head with three younger entries
      do_reset();
      drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0); next_cycle();
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); next_cycle();
      drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); next_cycle();
      drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      #4;
      chk("br_issue_rob_id", 32'(issue_rob_id), 3);
      next_cycle();
      drive(1, 0, 0, 0, 1, 0, 'h55, 1, 'h100, 0);
      #4;
      chk("br_pre_clear", 32'(clear), 0);
      next_cycle();
      drive(1, 0, 0, 0, 1, 1, 'h66, 0, 0, 1);
      #4;
      chk("br_retire_edge_clear", 32'(clear), 0);
      next_cycle();
      drive(1, 1, 4, 0, 1, 0, 'h99, 0, 0, 0);
      #4;
      chk("br_clear", 32'(clear), 1);
      chk("br_redirect_pc", redirect_pc, 'h100);
      chk("br_rf_set_id", 32'(rf_set_id), 6);
      chk("br_rf_set_value", rf_set_value, 'h55);
      chk("br_issue_rob_id_0", 32'(issue_rob_id), 0);
      chk("br_full", 32'(full), 0);
      chk("br_qry_flushed", 32'(qry_ready1), 0);
      next_cycle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      #4;
      chk("br_clear_one_cycle", 32'(clear), 0);
      chk("br_issue_ignored", 32'(issue_rob_id), 0);
      chk("br_entry1_invalid", 32'(qry_ready1), 0);
      chk("br_rf_set_id_idle", 32'(rf_set_id), 0);
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
